// File: rtl/maze_char_mover_pkg.sv
// maze_pkg: shared types and constants for the maze character mover.
//   MAZE_DIM / MAZE_IDX_W : bitmap geometry (64x64 tiles, 12-bit tile index)
//   dir_e                 : 2-bit move direction, also the button lane index
//   mover_state_e         : mover FSM state encoding
//   tile_t                : 6-bit tile coordinate pair
//   tile_idx()            : bitmap index x + 64*y
package maze_pkg;

    localparam int MAZE_DIM   = 64;
    localparam int MAZE_IDX_W = 12;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        CHECK = 2'd2,
        WON   = 2'd3
    } mover_state_e;

    typedef struct packed {
        logic [5:0] x;
        logic [5:0] y;
    } tile_t;

    // With a 64-wide row, x + 64*y is simply {y, x}.
    function automatic logic [MAZE_IDX_W-1:0] tile_idx(input tile_t t);
        return {t.y, t.x};
    endfunction

endpackage

// File: rtl/maze_char_mover_if.sv
// maze_char_mover_if: game-side signal bundle of the character mover.
//   master : drives enable, load, raw buttons, maze bitmap/geometry, start/goal
//   slave  : the mover; drives char_x/char_y, won, move_count, bump
interface maze_char_mover_if;

    logic        enable;
    logic        load;
    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic [maze_pkg::MAZE_DIM*maze_pkg::MAZE_DIM-1:0] path_data;
    logic [6:0]  maze_width;
    logic [6:0]  maze_height;
    logic [6:0]  start_x;
    logic [6:0]  start_y;
    logic [6:0]  goal_x;
    logic [6:0]  goal_y;
    logic [6:0]  char_x;
    logic [6:0]  char_y;
    logic        won;
    logic [15:0] move_count;
    logic        bump;

    modport master (
        output enable, load, btn_up, btn_down, btn_left, btn_right,
        output path_data, maze_width, maze_height,
        output start_x, start_y, goal_x, goal_y,
        input  char_x, char_y, won, move_count, bump
    );

    modport slave (
        input  enable, load, btn_up, btn_down, btn_left, btn_right,
        input  path_data, maze_width, maze_height,
        input  start_x, start_y, goal_x, goal_y,
        output char_x, char_y, won, move_count, bump
    );

endinterface

// File: rtl/maze_char_mover_btn_conditioner.sv
// btn_conditioner: one push-button lane.
//   2-FF synchronizer -> debounce (level flips after DEBOUNCE_CYCLES stable
//   cycles) -> one-cycle request on the debounced rising edge, then auto-repeat
//   REPEAT_DELAY cycles later and every REPEAT_RATE cycles while held.
// Ports:
//   clk, reset (async, active-low)
//   btn_i : raw asynchronous button
//   req_o : registered one-cycle move request
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_RATE     = 6_250_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic req_o
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RPT_W   = $clog2(RPT_MAX) + 1;

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             rpt_phase_q;   // 0: waiting out the initial delay, 1: steady repeat
    logic             req_q;
    logic [DB_W-1:0]  db_cnt_q;
    logic [RPT_W-1:0] rpt_cnt_q;
    logic             db_flip;

    // The counter runs only while the synchronized input differs from the
    // accepted level, so any bounce back restarts the stability window.
    assign db_flip = (sync2_q != level_q) && (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            rpt_phase_q <= 1'b0;
            req_q       <= 1'b0;
            db_cnt_q    <= '0;
            rpt_cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            req_q   <= 1'b0;

            if (sync2_q == level_q || db_flip) begin
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end

            // A level change takes priority over a repeat tick landing on
            // the same edge, so release never emits a trailing request.
            if (db_flip) begin
                level_q     <= sync2_q;
                req_q       <= sync2_q;
                rpt_cnt_q   <= '0;
                rpt_phase_q <= 1'b0;
            end else if (level_q) begin
                if (!rpt_phase_q && rpt_cnt_q == RPT_W'(REPEAT_DELAY - 1)) begin
                    req_q       <= 1'b1;
                    rpt_cnt_q   <= '0;
                    rpt_phase_q <= 1'b1;
                end else if (rpt_phase_q && rpt_cnt_q == RPT_W'(REPEAT_RATE - 1)) begin
                    req_q     <= 1'b1;
                    rpt_cnt_q <= '0;
                end else begin
                    rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
                end
            end else begin
                rpt_cnt_q   <= '0;
                rpt_phase_q <= 1'b0;
            end
        end
    end

    assign req_o = req_q;

endmodule

// File: rtl/maze_char_mover.sv
// maze_char_mover: player movement controller feeding the maze renderer.
//   Conditions four buttons, arbitrates up > down > left > right, bounds-checks
//   the step, looks the target up in path_data one cycle later, and owns the
//   character position, win flag and saturating move counter.
// Ports:
//   clk, reset (async, active-low)
//   bus (slave) : enable/load/buttons/maze geometry in; char_x/char_y, won,
//                 move_count, bump out (all registered)
module maze_char_mover
    import maze_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_RATE     = 6_250_000
) (
    input  logic             clk,
    input  logic             reset,
    maze_char_mover_if.slave bus
);

    logic [3:0]   btn_raw;
    logic [3:0]   req;
    logic         req_any;
    dir_e         req_dir;
    tile_t        tgt_d;
    logic         edge_hit;
    logic         size_ok;
    logic         reject;

    mover_state_e state_q;
    tile_t        cur_q;
    tile_t        tgt_q;
    logic         won_q;
    logic         bump_q;
    logic [15:0]  move_count_q;

    // Lane index equals the dir_e encoding.
    assign btn_raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_conditioner #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
        ) u_btn (
            .clk   (clk),
            .reset (reset),
            .btn_i (btn_raw[i]),
            .req_o (req[i])
        );
    end

    assign req_any = |req;

    // Fixed priority; losers in the same cycle are simply dropped.
    always_comb begin
        req_dir = DIR_RIGHT;
        if (req[DIR_UP])        req_dir = DIR_UP;
        else if (req[DIR_DOWN]) req_dir = DIR_DOWN;
        else if (req[DIR_LEFT]) req_dir = DIR_LEFT;
    end

    // Using >= on the far edges also stops a character placed outside the
    // maze from walking further out or wrapping the 6-bit coordinate.
    always_comb begin
        tgt_d    = cur_q;
        edge_hit = 1'b0;
        case (req_dir)
            DIR_UP: begin
                edge_hit = (cur_q.y == 6'd0);
                tgt_d.y  = cur_q.y - 6'd1;
            end
            DIR_DOWN: begin
                edge_hit = ({1'b0, cur_q.y} >= bus.maze_height - 7'd1);
                tgt_d.y  = cur_q.y + 6'd1;
            end
            DIR_LEFT: begin
                edge_hit = (cur_q.x == 6'd0);
                tgt_d.x  = cur_q.x - 6'd1;
            end
            DIR_RIGHT: begin
                edge_hit = ({1'b0, cur_q.x} >= bus.maze_width - 7'd1);
                tgt_d.x  = cur_q.x + 6'd1;
            end
        endcase
    end

    assign size_ok = (bus.maze_width  != 7'd0) && (bus.maze_width  <= 7'd64) &&
                     (bus.maze_height != 7'd0) && (bus.maze_height <= 7'd64);
    assign reject  = edge_hit || !size_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            tgt_q        <= '0;
            won_q        <= 1'b0;
            bump_q       <= 1'b0;
            move_count_q <= '0;
        end else begin
            bump_q <= 1'b0;
            if (bus.load) begin
                // Overrides any request or in-flight CHECK this cycle.
                cur_q.x      <= bus.start_x[5:0];
                cur_q.y      <= bus.start_y[5:0];
                move_count_q <= '0;
                won_q        <= 1'b0;
                state_q      <= PLAY;
            end else begin
                case (state_q)
                    IDLE: ;
                    PLAY: begin
                        if (req_any && bus.enable) begin
                            if (reject) begin
                                bump_q <= 1'b1;
                            end else begin
                                tgt_q   <= tgt_d;
                                state_q <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        if (bus.path_data[tile_idx(tgt_q)]) begin
                            cur_q <= tgt_q;
                            if (move_count_q != 16'hFFFF) begin
                                move_count_q <= move_count_q + 16'd1;
                            end
                            if ({1'b0, tgt_q.x} == bus.goal_x && {1'b0, tgt_q.y} == bus.goal_y) begin
                                won_q   <= 1'b1;
                                state_q <= WON;
                            end else begin
                                state_q <= PLAY;
                            end
                        end else begin
                            bump_q  <= 1'b1;
                            state_q <= PLAY;
                        end
                    end
                    WON: ;
                endcase
            end
        end
    end

    assign bus.char_x     = {1'b0, cur_q.x};
    assign bus.char_y     = {1'b0, cur_q.y};
    assign bus.won        = won_q;
    assign bus.move_count = move_count_q;
    assign bus.bump       = bump_q;

endmodule

// File: tb/tb_maze_char_mover.sv
// tb_maze_char_mover: directed bench for maze_char_mover with
// DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.
// Inputs change and outputs are sampled on the falling edge. With a button
// pressed just before rising edge 1, its request is high after edge 6, a move
// lands after edge 8, a bounds bump shows after edge 7 and a wall bump after
// edge 8. Auto-repeat requests follow after edges 26, 34, 42, ...
module tb_maze_char_mover;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    maze_char_mover_if bus ();

    maze_char_mover #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_RATE     (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic open_tile(input int x, input int y);
        bus.path_data[x + 64 * y] = 1'b1;
    endtask

    task automatic do_load(input int sx, input int sy, input int gx, input int gy);
        bus.start_x = 7'(sx);
        bus.start_y = 7'(sy);
        bus.goal_x  = 7'(gx);
        bus.goal_y  = 7'(gy);
        bus.load    = 1'b1;
        @(negedge clk);
        bus.load    = 1'b0;
    endtask

    task automatic test_reset();
        cyc(3);
        total++; if (bus.char_x !== 7'd0) begin bad++; $display("FAIL reset char_x got=%0d exp=0", bus.char_x); end
        total++; if (bus.char_y !== 7'd0) begin bad++; $display("FAIL reset char_y got=%0d exp=0", bus.char_y); end
        total++; if (bus.won !== 1'b0) begin bad++; $display("FAIL reset won got=%b exp=0", bus.won); end
        total++; if (bus.move_count !== 16'd0) begin bad++; $display("FAIL reset move_count got=%0d exp=0", bus.move_count); end
        total++; if (bus.bump !== 1'b0) begin bad++; $display("FAIL reset bump got=%b exp=0", bus.bump); end
        reset = 1'b1;
        cyc(2);
    endtask

    // (2,1) open, (3,1) wall: first request moves, repeat at 26 bumps the wall.
    task automatic test_single_move();
        bus.path_data = '0;
        open_tile(1, 1); open_tile(2, 1);
        do_load(1, 1, 5, 5);
        bus.btn_right = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 7) begin
                total++; if (bus.char_x !== 7'd1) begin bad++; $display("FAIL single char_x@7 got=%0d exp=1", bus.char_x); end
            end
            if (k == 8) begin
                total++; if (bus.char_x !== 7'd2) begin bad++; $display("FAIL single char_x@8 got=%0d exp=2", bus.char_x); end
                total++; if (bus.move_count !== 16'd1) begin bad++; $display("FAIL single count@8 got=%0d exp=1", bus.move_count); end
            end
            if (k == 28) begin
                total++; if (bus.bump !== 1'b1) begin bad++; $display("FAIL single repeat_bump@28 got=%b exp=1", bus.bump); end
            end
        end
        bus.btn_right = 1'b0;
        cyc(15);
        total++; if (bus.char_x !== 7'd2) begin bad++; $display("FAIL single final char_x got=%0d exp=2", bus.char_x); end
        total++; if (bus.move_count !== 16'd1) begin bad++; $display("FAIL single final count got=%0d exp=1", bus.move_count); end
    endtask

    // Row y=1 open for x=1..6, wall at x=7: five moves, then a wall bump.
    task automatic test_auto_repeat();
        bus.path_data = '0;
        for (int x = 1; x <= 6; x++) open_tile(x, 1);
        do_load(1, 1, 9, 9);
        bus.btn_right = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 27) begin
                total++; if (bus.char_x !== 7'd2) begin bad++; $display("FAIL repeat char_x@27 got=%0d exp=2", bus.char_x); end
            end
            if (k == 28) begin
                total++; if (bus.char_x !== 7'd3) begin bad++; $display("FAIL repeat char_x@28 got=%0d exp=3", bus.char_x); end
            end
            if (k == 36) begin
                total++; if (bus.char_x !== 7'd4) begin bad++; $display("FAIL repeat char_x@36 got=%0d exp=4", bus.char_x); end
            end
            if (k == 44) begin
                total++; if (bus.char_x !== 7'd5) begin bad++; $display("FAIL repeat char_x@44 got=%0d exp=5", bus.char_x); end
            end
            if (k == 52) begin
                total++; if (bus.char_x !== 7'd6) begin bad++; $display("FAIL repeat char_x@52 got=%0d exp=6", bus.char_x); end
            end
            if (k == 60) begin
                total++; if (bus.bump !== 1'b1) begin bad++; $display("FAIL repeat wall_bump@60 got=%b exp=1", bus.bump); end
            end
        end
        bus.btn_right = 1'b0;
        cyc(15);
        total++; if (bus.char_x !== 7'd6) begin bad++; $display("FAIL repeat final char_x got=%0d exp=6", bus.char_x); end
        total++; if (bus.move_count !== 16'd5) begin bad++; $display("FAIL repeat final count got=%0d exp=5", bus.move_count); end
    endtask

    task automatic test_bump();
        bus.path_data = '0;
        open_tile(0, 1); open_tile(1, 1); open_tile(2, 1);
        // Wall at (1,0): bump at n+2 only.
        do_load(1, 1, 5, 5);
        bus.btn_up = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 7 || k == 9) begin
                total++; if (bus.bump !== 1'b0) begin bad++; $display("FAIL wall bump@%0d got=%b exp=0", k, bus.bump); end
            end
            if (k == 8) begin
                total++; if (bus.bump !== 1'b1) begin bad++; $display("FAIL wall bump@8 got=%b exp=1", bus.bump); end
            end
        end
        bus.btn_up = 1'b0;
        cyc(12);
        total++; if (bus.char_y !== 7'd1 || bus.char_x !== 7'd1) begin bad++; $display("FAIL wall pos got=(%0d,%0d) exp=(1,1)", bus.char_x, bus.char_y); end
        // Left at x=0: bump at n+1 only.
        do_load(0, 1, 5, 5);
        bus.btn_left = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 6 || k == 8) begin
                total++; if (bus.bump !== 1'b0) begin bad++; $display("FAIL edge bump@%0d got=%b exp=0", k, bus.bump); end
            end
            if (k == 7) begin
                total++; if (bus.bump !== 1'b1) begin bad++; $display("FAIL edge bump@7 got=%b exp=1", bus.bump); end
            end
        end
        bus.btn_left = 1'b0;
        cyc(12);
        total++; if (bus.char_x !== 7'd0 || bus.move_count !== 16'd0) begin bad++; $display("FAIL edge state got x=%0d cnt=%0d exp x=0 cnt=0", bus.char_x, bus.move_count); end
        // Illegal maze width rejects even an open target.
        bus.maze_width = 7'd0;
        do_load(1, 1, 5, 5);
        bus.btn_right = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 7) begin
                total++; if (bus.bump !== 1'b1) begin bad++; $display("FAIL width0 bump@7 got=%b exp=1", bus.bump); end
            end
        end
        bus.btn_right = 1'b0;
        cyc(12);
        total++; if (bus.char_x !== 7'd1) begin bad++; $display("FAIL width0 char_x got=%0d exp=1", bus.char_x); end
        bus.maze_width = 7'd8;
    endtask

    task automatic test_glitch_and_enable();
        bus.path_data = '0;
        open_tile(1, 1); open_tile(1, 0); open_tile(2, 1);
        do_load(1, 1, 5, 5);
        bus.btn_up = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 2) bus.btn_up = 1'b0;
            total++; if (bus.bump !== 1'b0) begin bad++; $display("FAIL glitch bump@%0d got=%b exp=0", k, bus.bump); end
        end
        total++; if (bus.char_y !== 7'd1 || bus.move_count !== 16'd0) begin bad++; $display("FAIL glitch state got y=%0d cnt=%0d exp y=1 cnt=0", bus.char_y, bus.move_count); end
        bus.enable = 1'b0;
        bus.btn_right = 1'b1;
        cyc(10);
        bus.btn_right = 1'b0;
        cyc(12);
        total++; if (bus.char_x !== 7'd1 || bus.move_count !== 16'd0) begin bad++; $display("FAIL enable_low state got x=%0d cnt=%0d exp x=1 cnt=0", bus.char_x, bus.move_count); end
        bus.enable = 1'b1;
    endtask

    task automatic test_priority_and_win();
        bus.path_data = '0;
        open_tile(2, 4); open_tile(2, 3); open_tile(3, 4); open_tile(3, 3);
        do_load(2, 4, 3, 3);
        bus.btn_up = 1'b1;
        bus.btn_right = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 8) begin
                total++; if (bus.char_x !== 7'd2 || bus.char_y !== 7'd3) begin bad++; $display("FAIL prio pos got=(%0d,%0d) exp=(2,3)", bus.char_x, bus.char_y); end
            end
        end
        bus.btn_up = 1'b0;
        bus.btn_right = 1'b0;
        cyc(12);
        total++; if (bus.move_count !== 16'd1) begin bad++; $display("FAIL prio count got=%0d exp=1", bus.move_count); end
        bus.btn_right = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 7) begin
                total++; if (bus.won !== 1'b0) begin bad++; $display("FAIL win won@7 got=%b exp=0", bus.won); end
            end
            if (k == 8) begin
                total++; if (bus.won !== 1'b1) begin bad++; $display("FAIL win won@8 got=%b exp=1", bus.won); end
                total++; if (bus.char_x !== 7'd3 || bus.char_y !== 7'd3) begin bad++; $display("FAIL win pos got=(%0d,%0d) exp=(3,3)", bus.char_x, bus.char_y); end
            end
        end
        bus.btn_right = 1'b0;
        cyc(12);
        bus.btn_down = 1'b1;
        cyc(10);
        bus.btn_down = 1'b0;
        cyc(12);
        total++; if (bus.char_y !== 7'd3 || bus.move_count !== 16'd2 || bus.won !== 1'b1) begin bad++; $display("FAIL won_hold got y=%0d cnt=%0d won=%b exp y=3 cnt=2 won=1", bus.char_y, bus.move_count, bus.won); end
        do_load(2, 4, 3, 3);
        total++; if (bus.char_x !== 7'd2 || bus.char_y !== 7'd4) begin bad++; $display("FAIL reload pos got=(%0d,%0d) exp=(2,4)", bus.char_x, bus.char_y); end
        total++; if (bus.won !== 1'b0 || bus.move_count !== 16'd0) begin bad++; $display("FAIL reload won=%b cnt=%0d exp won=0 cnt=0", bus.won, bus.move_count); end
        do_load(3, 3, 3, 3);
        cyc(3);
        total++; if (bus.won !== 1'b0) begin bad++; $display("FAIL start_is_goal won got=%b exp=0", bus.won); end
    endtask

    task automatic test_load_in_check_and_reset();
        bus.path_data = '0;
        open_tile(1, 1); open_tile(2, 1);
        do_load(1, 1, 5, 5);
        bus.btn_right = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 7) bus.load = 1'b1;
            if (k == 8) begin
                bus.load = 1'b0;
                total++; if (bus.char_x !== 7'd1) begin bad++; $display("FAIL load_check char_x got=%0d exp=1", bus.char_x); end
                total++; if (bus.move_count !== 16'd0) begin bad++; $display("FAIL load_check count got=%0d exp=0", bus.move_count); end
            end
        end
        bus.btn_right = 1'b0;
        cyc(12);
        total++; if (bus.char_x !== 7'd1) begin bad++; $display("FAIL load_check final char_x got=%0d exp=1", bus.char_x); end
        // Reset during the CHECK cycle of a legal move.
        bus.btn_right = 1'b1;
        cyc(7);
        reset = 1'b0;
        #1;
        total++; if (bus.char_x !== 7'd0 || bus.char_y !== 7'd0) begin bad++; $display("FAIL midreset pos got=(%0d,%0d) exp=(0,0)", bus.char_x, bus.char_y); end
        total++; if (bus.won !== 1'b0 || bus.bump !== 1'b0 || bus.move_count !== 16'd0) begin bad++; $display("FAIL midreset won=%b bump=%b cnt=%0d exp all 0", bus.won, bus.bump, bus.move_count); end
        bus.btn_right = 1'b0;
        cyc(3);
        reset = 1'b1;
        cyc(2);
        // Back in IDLE: a press must be ignored.
        bus.btn_right = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            total++; if (bus.bump !== 1'b0) begin bad++; $display("FAIL idle bump@%0d got=%b exp=0", k, bus.bump); end
        end
        bus.btn_right = 1'b0;
        cyc(12);
        total++; if (bus.char_x !== 7'd0 || bus.move_count !== 16'd0) begin bad++; $display("FAIL idle state got x=%0d cnt=%0d exp x=0 cnt=0", bus.char_x, bus.move_count); end
    endtask

    initial begin
        bus.enable      = 1'b1;
        bus.load        = 1'b0;
        bus.btn_up      = 1'b0;
        bus.btn_down    = 1'b0;
        bus.btn_left    = 1'b0;
        bus.btn_right   = 1'b0;
        bus.path_data   = '0;
        bus.maze_width  = 7'd8;
        bus.maze_height = 7'd8;
        bus.start_x     = 7'd0;
        bus.start_y     = 7'd0;
        bus.goal_x      = 7'd0;
        bus.goal_y      = 7'd0;

        test_reset();
        test_single_move();
        test_auto_repeat();
        test_bump();
        test_glitch_and_enable();
        test_priority_and_win();
        test_load_in_check_and_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
